hex_page_scheduler: RTL and testbench
=====================================

HEX_PAGE_SCHEDULER -- requirements
Module: hex_page_scheduler

Interface
REQ-001 SHALL have parameter PAGE_TICKS, default 100000000, clock cycles per debug page.
REQ-002 SHALL have parameter BLINK_TICKS, default 25000000, clock cycles per game-over blink phase.
REQ-003 SHALL have parameter REFRESH_TICKS, default 5000000, clock cycles between periodic value resamples.
REQ-004 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port displayMode  input  3  one-hot mode: 001 normal, 010 game over, 100 debug.
REQ-007 SHALL have port score  input  16  current score, unsigned binary.
REQ-008 SHALL have port snakeLength  input  8  debug page 0 value.
REQ-009 SHALL have port headX  input  8  debug page 1 value.
REQ-010 SHALL have port headY  input  8  debug page 2 value.
REQ-011 SHALL have port digitValue  output  24  six BCD nibbles; bits [4i+3:4i] = digit i, digit 0 least significant.
REQ-012 SHALL have port digitBlank  output  6  bit i = 1 blanks digit i.
REQ-013 SHALL have port pageIndex  output  2  current debug page, 0..2.
REQ-014 SHALL have port updateStrobe  output  1  one-cycle pulse when digitValue/digitBlank are reloaded.
REQ-015 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-016 Any displayMode value that is not one-hot SHALL be treated as normal.
REQ-017 Conversion FSM states: IDLE, LOAD, SHIFT, DONE; IDLE->LOAD on trigger; LOAD->SHIFT; SHIFT repeats 16 times; ->DONE; DONE->IDLE, or DONE->LOAD if a trigger is pending.
REQ-018 LOAD SHALL sample the source: normal/game over = score; debug = {8'h00, snakeLength/headX/headY} selected by pageIndex.
REQ-019 SHIFT SHALL perform one shift-add-3 (double-dabble) iteration per cycle into a 24-bit BCD register; no truncation for 0..65535.
REQ-020 Latency: trigger sampled at edge N; digitValue, digitBlank and updateStrobe SHALL be registered at edge N+18; updateStrobe SHALL be high for exactly one cycle.
REQ-021 Triggers: first cycle after reset release; any change of the decoded mode; any pageIndex change; refresh counter reaching REFRESH_TICKS-1. The refresh counter SHALL restart on every trigger.
REQ-022 A trigger while busy SHALL set a single pending flag; multiple triggers while busy SHALL collapse into one extra conversion.
REQ-023 busy SHALL be high in LOAD, SHIFT and DONE.
REQ-024 Blank mask, normal/game over: leading-zero digits blanked; digit 0 never blanked by this rule.
REQ-025 Blank mask, debug: digits 3 and 4 always blanked; digits 1-2 leading-zero blanked; digit 5 SHALL show pageIndex+1, unblanked.
REQ-026 Debug: pageIndex SHALL advance every PAGE_TICKS cycles, 2 wraps to 0; on entering debug, pageIndex and page counter SHALL clear to 0.
REQ-027 Game over: blink phase SHALL toggle every BLINK_TICKS cycles; while phase = 1, digitBlank output SHALL be 6'b111111 combinationally overriding the registered mask; on entering game over, phase SHALL clear to 0 (visible).
REQ-028 Outside game over, blink phase SHALL be held at 0; outside debug, pageIndex SHALL hold at 0.

Reset
REQ-029 On reset: digitValue = 0, registered mask = 6'b111110, pageIndex = 0, updateStrobe = 0, busy = 0, FSM = IDLE, all counters, pending flag and blink phase = 0.
REQ-030 Reset asserted mid-conversion SHALL abort it immediately, without waiting for a clock edge; no updateStrobe SHALL be produced for the aborted conversion.

Verification (PAGE_TICKS=40, BLINK_TICKS=10, REFRESH_TICKS=30)
REQ-031 Release reset, mode 001, score=1234 -> at edge 18 after first trigger: digitValue=24'h001234, digitBlank=6'b110000, one updateStrobe.
REQ-032 score=65535 -> 24'h065535, mask 6'b100000; score=0 -> 24'h000000, mask 6'b111110.
REQ-033 Mode 100, snakeLength=7, headX=12, headY=200 -> page 0: digitValue=24'h100007, mask 6'b011110; after 40 cycles page 1: 24'h200012, mask 6'b011100; after 120 cycles back to page 0.
REQ-034 Mode 010, score=50 -> digitBlank 6'b111100 for 10 cycles, 6'b111111 for 10 cycles, repeating; switching to 100 mid-blank -> blink cleared and pageIndex=0.
REQ-035 Three mode changes during one conversion -> exactly two updateStrobe pulses total; the second conversion starts in the cycle after DONE.
REQ-036 Reset pulse during SHIFT -> all outputs at their reset values with no clock edge required; no strobe; normal operation resumes after release.

Source files
------------

// File: rtl/hex_page_scheduler.sv
// Six-digit hex-display scheduler: picks a score or debug value, converts it to BCD by
// double-dabble and publishes digits, blank mask and a reload strobe.
module hex_page_scheduler #(
  parameter int unsigned PAGE_TICKS    = 100000000,
  parameter int unsigned BLINK_TICKS   = 25000000,
  parameter int unsigned REFRESH_TICKS = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  displayMode,
  input  logic [15:0] score,
  input  logic [7:0]  snakeLength,
  input  logic [7:0]  headX,
  input  logic [7:0]  headY,
  output logic [23:0] digitValue,
  output logic [5:0]  digitBlank,
  output logic [1:0]  pageIndex,
  output logic        updateStrobe,
  output logic        busy
);

  localparam int unsigned PW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int unsigned RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [PW-1:0] PAGE_LAST    = PW'(PAGE_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_TICKS - 1);

  typedef enum logic [1:0] {ModeNormal, ModeOver, ModeDebug} mode_e;
  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  mode_e         w_mode;
  mode_e         r_mode;
  logic          r_started;
  logic [1:0]    r_page;
  logic [PW-1:0] r_page_cnt;
  logic          r_phase;
  logic [BW-1:0] r_blink_cnt;
  logic [RW-1:0] r_refresh_cnt;

  logic w_mode_chg;
  logic w_page_adv;
  logic w_refresh_hit;
  logic w_trigger;

  state_e      r_state;
  logic        r_pending;
  logic [23:0] r_bcd;
  logic [15:0] r_bin;
  logic [3:0]  r_shift_cnt;
  logic        r_conv_debug;
  logic [1:0]  r_conv_page;
  logic [23:0] r_value;
  logic [5:0]  r_mask;
  logic        r_strobe;

  logic [15:0] w_src;
  logic [39:0] w_shifted;
  logic [23:0] w_value;
  logic [5:0]  w_mask;
  logic        w_lz;

  function automatic logic [23:0] f_add3(input logic [23:0] b);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Anything other than a clean one-hot code falls back to normal.
  always_comb begin
    case (displayMode)
      3'b010:  w_mode = ModeOver;
      3'b100:  w_mode = ModeDebug;
      default: w_mode = ModeNormal;
    endcase
  end

  assign w_mode_chg    = (w_mode != r_mode);
  assign w_page_adv    = (w_mode == ModeDebug) && (r_mode == ModeDebug) && (r_page_cnt == PAGE_LAST);
  assign w_refresh_hit = (r_refresh_cnt == REFRESH_LAST);
  assign w_trigger     = !r_started || w_mode_chg || w_page_adv || w_refresh_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode        <= ModeNormal;
      r_started     <= 1'b0;
      r_page        <= 2'd0;
      r_page_cnt    <= '0;
      r_phase       <= 1'b0;
      r_blink_cnt   <= '0;
      r_refresh_cnt <= '0;
    end else begin
      r_mode    <= w_mode;
      r_started <= 1'b1;
      r_refresh_cnt <= w_trigger ? '0 : r_refresh_cnt + RW'(1);

      // Entering debug (or being outside it) restarts paging from page 0.
      if (w_mode != ModeDebug || r_mode != ModeDebug) begin
        r_page     <= 2'd0;
        r_page_cnt <= '0;
      end else if (r_page_cnt == PAGE_LAST) begin
        r_page     <= (r_page == 2'd2) ? 2'd0 : r_page + 2'd1;
        r_page_cnt <= '0;
      end else begin
        r_page_cnt <= r_page_cnt + PW'(1);
      end

      if (w_mode != ModeOver || r_mode != ModeOver) begin
        r_phase     <= 1'b0;
        r_blink_cnt <= '0;
      end else if (r_blink_cnt == BLINK_LAST) begin
        r_phase     <= ~r_phase;
        r_blink_cnt <= '0;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    case (r_page)
      2'd0:    w_src = {8'h00, snakeLength};
      2'd1:    w_src = {8'h00, headX};
      default: w_src = {8'h00, headY};
    endcase
    if (r_mode != ModeDebug) w_src = score;
  end

  assign w_shifted = {f_add3(r_bcd), r_bin} << 1;

  always_comb begin
    w_value = r_bcd;
    w_mask  = 6'b000000;
    w_lz    = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      w_lz      = w_lz & (r_bcd[4*i +: 4] == 4'd0);
      w_mask[i] = w_lz;
    end
    if (r_conv_debug) begin
      w_value = {2'b00, r_conv_page + 2'd1, 8'h00, r_bcd[11:0]};
      w_mask  = {1'b0, 2'b11, r_bcd[11:8] == 4'd0, r_bcd[11:4] == 8'd0, 1'b0};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_pending    <= 1'b0;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_shift_cnt  <= '0;
      r_conv_debug <= 1'b0;
      r_conv_page  <= 2'd0;
      r_value      <= '0;
      r_mask       <= 6'b111110;
      r_strobe     <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_trigger) r_state <= StLoad;
        end
        StLoad: begin
          r_bin        <= w_src;
          r_bcd        <= '0;
          r_shift_cnt  <= '0;
          r_conv_debug <= (r_mode == ModeDebug);
          r_conv_page  <= r_page;
          if (w_trigger) r_pending <= 1'b1;
          r_state <= StShift;
        end
        StShift: begin
          r_bcd       <= w_shifted[39:16];
          r_bin       <= w_shifted[15:0];
          r_shift_cnt <= r_shift_cnt + 4'd1;
          if (w_trigger) r_pending <= 1'b1;
          if (r_shift_cnt == 4'd15) r_state <= StDone;
        end
        default: begin
          r_value   <= w_value;
          r_mask    <= w_mask;
          r_strobe  <= 1'b1;
          r_pending <= 1'b0;
          r_state   <= (r_pending || w_trigger) ? StLoad : StIdle;
        end
      endcase
    end
  end

  assign digitValue   = r_value;
  assign digitBlank   = r_phase ? 6'b111111 : r_mask;
  assign pageIndex    = r_page;
  assign updateStrobe = r_strobe;
  assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_hex_page_scheduler.sv
// Bench for hex_page_scheduler: vector table, random scores against a decimal model,
// and hand sequences for latency, paging, blinking, trigger collapse and async reset.
module tb_hex_page_scheduler;

  logic        clock;
  logic        reset;
  logic [2:0]  displayMode;
  logic [15:0] score;
  logic [7:0]  snakeLength;
  logic [7:0]  headX;
  logic [7:0]  headY;
  logic [23:0] digitValue;
  logic [5:0]  digitBlank;
  logic [1:0]  pageIndex;
  logic        updateStrobe;
  logic        busy;

  int n_pass;
  int n_total;

  hex_page_scheduler #(
    .PAGE_TICKS   (40),
    .BLINK_TICKS  (10),
    .REFRESH_TICKS(30)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .displayMode (displayMode),
    .score       (score),
    .snakeLength (snakeLength),
    .headX       (headX),
    .headY       (headY),
    .digitValue  (digitValue),
    .digitBlank  (digitBlank),
    .pageIndex   (pageIndex),
    .updateStrobe(updateStrobe),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] sc;
    logic [23:0] val;
    logic [5:0]  blk;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic wait_strobe(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!updateStrobe && n < 200);
    if (!updateStrobe) begin
      n_total++;
      $display("FAIL %s: updateStrobe got 0 within 200 cycles, required 1", name);
    end
  endtask

  function automatic logic [23:0] model_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_blank(input int unsigned v);
    int          nd;
    int unsigned t;
    logic [5:0]  b;
    nd = 1;
    t  = v / 10;
    while (t != 0) begin
      nd++;
      t = t / 10;
    end
    for (int i = 0; i < 6; i++) b[i] = (i >= nd);
    return b;
  endfunction

  initial begin
    vec_t        vecs[6];
    int          first_k;
    int          n_str;
    int          j1;
    int          j2;
    int          guard;
    logic [23:0] val2;
    int unsigned rs;

    vecs[0] = '{16'd1234,  24'h001234, 6'b110000};
    vecs[1] = '{16'd65535, 24'h065535, 6'b100000};
    vecs[2] = '{16'd0,     24'h000000, 6'b111110};
    vecs[3] = '{16'd9,     24'h000009, 6'b111110};
    vecs[4] = '{16'd10,    24'h000010, 6'b111100};
    vecs[5] = '{16'd60000, 24'h060000, 6'b100000};

    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    displayMode = 3'b001;
    score = 16'd1234;
    snakeLength = 8'd7;
    headX = 8'd12;
    headY = 8'd200;

    repeat (3) @(negedge clock);
    check("reset digitValue", 32'(digitValue), 32'h0);
    check("reset digitBlank", 32'(digitBlank), 32'h3E);
    check("reset pageIndex", 32'(pageIndex), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset strobe", 32'(updateStrobe), 32'h0);

    // First trigger is the edge right after release; result lands 18 edges later.
    reset = 1'b0;
    first_k = 0;
    for (int k = 1; k <= 40 && first_k == 0; k++) begin
      @(negedge clock);
      if (k == 18) check("busy before done", 32'(busy), 32'h1);
      if (updateStrobe) first_k = k;
    end
    check("first strobe edge", 32'(first_k), 32'd19);
    check("first digitValue", 32'(digitValue), 32'h001234);
    check("first digitBlank", 32'(digitBlank), 32'h30);
    check("busy after done", 32'(busy), 32'h0);
    @(negedge clock);
    check("strobe one cycle", 32'(updateStrobe), 32'h0);

    for (int i = 0; i < 6; i++) begin
      score = vecs[i].sc;
      wait_strobe("table");
      wait_strobe("table");
      check($sformatf("table[%0d] digitValue", i), 32'(digitValue), 32'(vecs[i].val));
      check($sformatf("table[%0d] digitBlank", i), 32'(digitBlank), 32'(vecs[i].blk));
    end

    for (int i = 0; i < 16; i++) begin
      rs = $urandom_range(0, 65535);
      score = 16'(rs);
      wait_strobe("random");
      wait_strobe("random");
      check($sformatf("random %0d digitValue", rs), 32'(digitValue), 32'(model_bcd(rs)));
      check($sformatf("random %0d digitBlank", rs), 32'(digitBlank), 32'(model_blank(rs)));
    end

    // Game over blink: entry edge starts visible phase, toggling every 10 edges.
    score = 16'd50;
    wait_strobe("blink prep");
    wait_strobe("blink prep");
    displayMode = 3'b010;
    for (int j = 0; j < 35; j++) begin
      @(negedge clock);
      check($sformatf("blink j=%0d", j), 32'(digitBlank), ((j / 10) % 2) ? 32'h3F : 32'h3C);
    end

    // Leave game over mid-blank for debug; then follow the page rotation.
    displayMode = 3'b100;
    for (int j = 0; j < 160; j++) begin
      @(negedge clock);
      if (j == 0) check("debug entry blank", 32'(digitBlank), 32'h3C);
      check($sformatf("page j=%0d", j), 32'(pageIndex), 32'((j / 40) % 3));
      if (j == 39) begin
        check("page0 value", 32'(digitValue), 32'h100007);
        check("page0 blank", 32'(digitBlank), 32'h1E);
      end
      if (j == 79) begin
        check("page1 value", 32'(digitValue), 32'h200012);
        check("page1 blank", 32'(digitBlank), 32'h1C);
      end
      if (j == 119) begin
        check("page2 value", 32'(digitValue), 32'h300200);
        check("page2 blank", 32'(digitBlank), 32'h18);
      end
      if (j == 159) begin
        check("page0 again value", 32'(digitValue), 32'h100007);
        check("page0 again blank", 32'(digitBlank), 32'h1E);
      end
    end

    // Back to normal and wait for an idle point before the collapse test.
    displayMode = 3'b001;
    guard = 0;
    do begin
      wait_strobe("settle");
      guard++;
    end while (busy && guard < 10);
    check("settle idle", 32'(busy), 32'h0);

    displayMode = 3'b010;
    n_str = 0;
    j1 = -1;
    j2 = -1;
    val2 = '0;
    for (int j = 0; j < 38; j++) begin
      @(negedge clock);
      if (j == 2) displayMode = 3'b100;
      if (j == 5) displayMode = 3'b001;
      if (j == 8) displayMode = 3'b010;
      if (updateStrobe) begin
        n_str++;
        if (j1 < 0) j1 = j;
        else if (j2 < 0) begin
          j2 = j;
          val2 = digitValue;
        end
      end
    end
    check("collapse strobe count", 32'(n_str), 32'd2);
    check("collapse first strobe", 32'(j1), 32'd18);
    check("collapse second strobe", 32'(j2), 32'd36);
    check("collapse second value", 32'(val2), 32'h000050);

    // Asynchronous reset in the middle of a conversion.
    displayMode = 3'b001;
    repeat (6) @(posedge clock);
    #2;
    check("busy before reset", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("async digitValue", 32'(digitValue), 32'h0);
    check("async digitBlank", 32'(digitBlank), 32'h3E);
    check("async pageIndex", 32'(pageIndex), 32'h0);
    check("async busy", 32'(busy), 32'h0);
    check("async strobe", 32'(updateStrobe), 32'h0);
    score = 16'd4321;
    n_str = 0;
    repeat (3) begin
      @(negedge clock);
      if (updateStrobe) n_str++;
    end
    reset = 1'b0;
    first_k = 0;
    for (int k = 1; k <= 40 && first_k == 0; k++) begin
      @(negedge clock);
      if (updateStrobe) first_k = k;
    end
    check("strobes during reset", 32'(n_str), 32'd0);
    check("resume strobe edge", 32'(first_k), 32'd19);
    check("resume digitValue", 32'(digitValue), 32'h004321);
    check("resume digitBlank", 32'(digitBlank), 32'h30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
